// File: rtl/spi_pkg.sv
// Shared definitions for the synchronous SPI slave: control-register bit positions,
// the clock-mode pair and the FSM state encoding.
package spi_pkg;

    localparam int SPCON_SPEN = 0;
    localparam int SPCON_CPHA = 1;
    localparam int SPCON_CPOL = 2;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    // Modes 1 and 2 sample on the falling sck edge, modes 0 and 3 on the rising edge.
    function automatic logic sample_on_fall(input spi_mode_t m);
        return m.cpol ^ m.cpha;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave sampled entirely in the clk domain: pins are synchronized, sck edges
// become one-cycle events, and a two-state FSM moves bytes through the shift registers.
//
// state    | meaning
// ST_IDLE  | deselected or disabled; miso_oe low, waits for ssn falling with spen set
// ST_SHIFT | selected; rx/tx shift registers advance on sample/shift edges
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spcon_s,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       underrun,
    output logic       busy,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ssn,
    output logic       miso,
    output logic       miso_oe
);

    logic sck_rise, sck_fall;
    logic mosi_s;
    logic ssn_rise, ssn_fall;
    logic unused_sck_lvl, unused_ssn_lvl, unused_mosi_rise, unused_mosi_fall;
    logic unused_spcon;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sck),
        .q_o    (unused_sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (unused_mosi_rise),
        .fall_o (unused_mosi_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ssn),
        .q_o    (unused_ssn_lvl),
        .rise_o (ssn_rise),
        .fall_o (ssn_fall)
    );

    assign unused_spcon = ^spcon_s[7:3];

    spi_mode_t mode;
    logic      spen;
    logic      sample_evt, shift_evt;

    assign spen      = spcon_s[SPCON_SPEN];
    assign mode.cpol = spcon_s[SPCON_CPOL];
    assign mode.cpha = spcon_s[SPCON_CPHA];

    assign sample_evt = sample_on_fall(mode) ? sck_fall : sck_rise;
    assign shift_evt  = sample_on_fall(mode) ? sck_rise : sck_fall;

    spi_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       skip_q, skip_d;
    logic       urun_pend_q, urun_pend_d;
    logic       done_q, done_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       load_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            skip_q      <= 1'b0;
            urun_pend_q <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            skip_q      <= skip_d;
            urun_pend_q <= urun_pend_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        skip_d      = skip_q;
        urun_pend_d = urun_pend_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_tx     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spen && ssn_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 3'd0;
                    load_tx   = 1'b1;
                    skip_d    = mode.cpha;
                end
            end
            ST_SHIFT: begin
                if (!spen || ssn_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = 3'd0;
                    skip_d      = 1'b0;
                    urun_pend_d = 1'b0;
                end else if (sample_evt) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    // Underrun is reported once the byte really starts, so a reload
                    // at the end of the last byte of a transfer stays silent.
                    if (urun_pend_q) begin
                        underrun_d  = 1'b1;
                        urun_pend_d = 1'b0;
                    end
                    if (bit_cnt_q == 3'd7) begin
                        done_d  = 1'b1;
                        load_tx = 1'b1;
                        skip_d  = 1'b1;
                    end
                end else if (shift_evt) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_tx) begin
            tx_shift_d  = hold_full_q ? hold_q : 8'hFF;
            urun_pend_d = ~hold_full_q;
            hold_full_d = 1'b0;
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        rx_valid_d = done_q;
        rx_data_d  = done_q ? rx_shift_q : rx_data_q;
    end

    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign busy     = (state_q == ST_SHIFT);
    assign miso_oe  = (state_q == ST_SHIFT);
    assign miso     = tx_shift_q[7];

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a bit-banged SPI master drives the pins while
// monitors count rx_valid/underrun pulses.
module tb_spi_slave_sync;

    localparam int NS = 2;
    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spcon_s;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       busy;
    logic       sck;
    logic       mosi;
    logic       ssn;
    logic       miso;
    logic       miso_oe;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rv_count = 0;
    int rv_cyc   = 0;
    int ur_count = 0;
    int edge8_cyc = 0;
    logic [7:0] rx_log [0:7];
    logic cpol_m = 1'b0;
    logic cpha_m = 1'b0;

    spi_slave_sync #(.SYNC_STAGES(NS)) dut (
        .clk      (clk),
        .rst      (rst),
        .spcon_s  (spcon_s),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .busy     (busy),
        .sck      (sck),
        .mosi     (mosi),
        .ssn      (ssn),
        .miso     (miso),
        .miso_oe  (miso_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rv_count % 8] = rx_data;
            rv_count = rv_count + 1;
            rv_cyc   = cyc;
        end
        if (underrun) ur_count = ur_count + 1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [7:0] v);
        spcon_s = v;
        cpol_m  = v[2];
        cpha_m  = v[1];
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        clk_wait(1);
        tx_valid = 1'b0;
    endtask

    task automatic begin_xfer();
        sck = cpol_m;
        ssn = 1'b1;
        clk_wait(6);
        ssn = 1'b0;
        clk_wait(HP);
    endtask

    task automatic end_xfer();
        clk_wait(HP);
        ssn = 1'b1;
        clk_wait(12);
    endtask

    task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (!cpha_m) begin
                mosi = mo[i];
                clk_wait(HP);
                sck = ~cpol_m;
                mi[i] = miso;
                if (i == 0) edge8_cyc = cyc;
                clk_wait(HP);
                sck = cpol_m;
            end else begin
                clk_wait(HP);
                sck = ~cpol_m;
                mosi = mo[i];
                clk_wait(HP);
                sck = cpol_m;
                mi[i] = miso;
                if (i == 0) edge8_cyc = cyc;
            end
        end
    endtask

    task automatic sck_edges(input int n);
        for (int i = 0; i < n; i++) begin
            clk_wait(HP);
            mosi = ~mosi;
            sck  = ~sck;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(6);
        checks++; if (tx_ready !== 1'b1)  begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00)  begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)  begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (underrun !== 1'b0)  begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (miso !== 1'b0)      begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
        checks++; if (miso_oe !== 1'b0)   begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    endtask

    task automatic test_mode0();
        logic [7:0] mi;
        int rv0, ur0;
        set_mode(8'h01);
        push_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mode0_hold_full got=%b exp=0", tx_ready); end
        rv0 = rv_count; ur0 = ur_count;
        begin_xfer();
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL mode0_busy got=%b exp=1", busy); end
        checks++; if (miso_oe !== 1'b1) begin failures++; $display("FAIL mode0_miso_oe got=%b exp=1", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL mode0_hold_freed got=%b exp=1", tx_ready); end
        xfer_byte(8'h3C, mi);
        end_xfer();
        checks++; if (rv_count - rv0 !== 1) begin failures++; $display("FAIL mode0_rv_pulses got=%0d exp=1", rv_count - rv0); end
        checks++; if (rx_data !== 8'h3C)  begin failures++; $display("FAIL mode0_rx_data got=%h exp=3c", rx_data); end
        checks++; if (rx_log[rv0 % 8] !== 8'h3C) begin failures++; $display("FAIL mode0_rx_at_pulse got=%h exp=3c", rx_log[rv0 % 8]); end
        checks++; if (mi !== 8'hA5)       begin failures++; $display("FAIL mode0_master_rx got=%h exp=a5", mi); end
        checks++; if (rv_cyc - edge8_cyc !== NS + 2) begin failures++; $display("FAIL mode0_rv_latency got=%0d exp=%0d", rv_cyc - edge8_cyc, NS + 2); end
        checks++; if (ur_count - ur0 !== 0) begin failures++; $display("FAIL mode0_no_underrun got=%0d exp=0", ur_count - ur0); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mode0_busy_end got=%b exp=0", busy); end
        checks++; if (miso_oe !== 1'b0)   begin failures++; $display("FAIL mode0_oe_end got=%b exp=0", miso_oe); end
    endtask

    task automatic test_modes();
        logic [7:0] modes [4];
        logic [7:0] txb [4];
        logic [7:0] mi;
        int rv0, ur0;
        modes = '{8'h01, 8'h03, 8'h05, 8'h07};
        txb   = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
        for (int m = 0; m < 4; m++) begin
            set_mode(modes[m]);
            push_tx(txb[m]);
            rv0 = rv_count; ur0 = ur_count;
            begin_xfer();
            xfer_byte(8'h96, mi);
            end_xfer();
            checks++; if (rv_count - rv0 !== 1) begin failures++; $display("FAIL modes_rv_pulses spcon=%h got=%0d exp=1", modes[m], rv_count - rv0); end
            checks++; if (rx_data !== 8'h96)   begin failures++; $display("FAIL modes_rx spcon=%h got=%h exp=96", modes[m], rx_data); end
            checks++; if (mi !== txb[m])       begin failures++; $display("FAIL modes_master_rx spcon=%h got=%h exp=%h", modes[m], mi, txb[m]); end
            checks++; if (ur_count - ur0 !== 0) begin failures++; $display("FAIL modes_underrun spcon=%h got=%0d exp=0", modes[m], ur_count - ur0); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int rv0, ur0;
        set_mode(8'h01);
        rv0 = rv_count; ur0 = ur_count;
        begin_xfer();
        xfer_byte(8'h5E, mi);
        end_xfer();
        checks++; if (ur_count - ur0 !== 1) begin failures++; $display("FAIL underrun_pulses got=%0d exp=1", ur_count - ur0); end
        checks++; if (mi !== 8'hFF)        begin failures++; $display("FAIL underrun_master_rx got=%h exp=ff", mi); end
        checks++; if (rx_data !== 8'h5E)   begin failures++; $display("FAIL underrun_rx got=%h exp=5e", rx_data); end
        checks++; if (rv_count - rv0 !== 1) begin failures++; $display("FAIL underrun_rv_pulses got=%0d exp=1", rv_count - rv0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi1, mi2;
        int rv0, ur0;
        set_mode(8'h01);
        push_tx(8'h11);
        rv0 = rv_count; ur0 = ur_count;
        begin_xfer();
        fork
            begin
                xfer_byte(8'hC6, mi1);
                xfer_byte(8'h39, mi2);
            end
            begin
                clk_wait(30);
                push_tx(8'h22);
            end
        join
        end_xfer();
        checks++; if (rv_count - rv0 !== 2) begin failures++; $display("FAIL b2b_rv_pulses got=%0d exp=2", rv_count - rv0); end
        checks++; if (rx_log[rv0 % 8] !== 8'hC6) begin failures++; $display("FAIL b2b_rx_first got=%h exp=c6", rx_log[rv0 % 8]); end
        checks++; if (rx_log[(rv0 + 1) % 8] !== 8'h39) begin failures++; $display("FAIL b2b_rx_second got=%h exp=39", rx_log[(rv0 + 1) % 8]); end
        checks++; if (mi1 !== 8'h11) begin failures++; $display("FAIL b2b_master_rx_first got=%h exp=11", mi1); end
        checks++; if (mi2 !== 8'h22) begin failures++; $display("FAIL b2b_master_rx_second got=%h exp=22", mi2); end
        checks++; if (ur_count - ur0 !== 0) begin failures++; $display("FAIL b2b_underrun got=%0d exp=0", ur_count - ur0); end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int rv0;
        set_mode(8'h01);
        push_tx(8'h77);
        rv0 = rv_count;
        begin_xfer();
        sck_edges(5);
        clk_wait(HP);
        ssn = 1'b1;
        clk_wait(12);
        checks++; if (rv_count - rv0 !== 0) begin failures++; $display("FAIL abort_rv_pulses got=%0d exp=0", rv_count - rv0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        sck = cpol_m;
        push_tx(8'hB4);
        begin_xfer();
        xfer_byte(8'hD2, mi);
        end_xfer();
        checks++; if (rv_count - rv0 !== 1) begin failures++; $display("FAIL abort_next_rv got=%0d exp=1", rv_count - rv0); end
        checks++; if (rx_data !== 8'hD2) begin failures++; $display("FAIL abort_next_rx got=%h exp=d2", rx_data); end
        checks++; if (mi !== 8'hB4)      begin failures++; $display("FAIL abort_next_master_rx got=%h exp=b4", mi); end
    endtask

    task automatic test_disable();
        logic [7:0] mi;
        int ur0;
        set_mode(8'h01);
        ur0 = ur_count;
        begin_xfer();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL disable_pre_busy got=%b exp=1", busy); end
        set_mode(8'h00);
        clk_wait(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL disable_forces_idle got=%b exp=0", busy); end
        ssn = 1'b1;
        clk_wait(6);
        push_tx(8'h99);
        ssn = 1'b0;
        clk_wait(12);
        sck_edges(4);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL disable_ignores_ssn got=%b exp=0", busy); end
        ssn = 1'b1;
        clk_wait(12);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL disable_hold_kept got=%b exp=0", tx_ready); end
        set_mode(8'h01);
        begin_xfer();
        xfer_byte(8'h4D, mi);
        end_xfer();
        checks++; if (mi !== 8'h99) begin failures++; $display("FAIL disable_hold_sent got=%h exp=99", mi); end
        checks++; if (rx_data !== 8'h4D) begin failures++; $display("FAIL disable_rx got=%h exp=4d", rx_data); end
        checks++; if (ur_count - ur0 !== 0) begin failures++; $display("FAIL disable_underrun got=%0d exp=0", ur_count - ur0); end
    endtask

    task automatic test_rst_mid();
        int rv0;
        set_mode(8'h01);
        push_tx(8'h3A);
        rv0 = rv_count;
        begin_xfer();
        push_tx(8'h5C);
        sck_edges(6);
        clk_wait(2);
        rst = 1'b1;
        clk_wait(2);
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (miso_oe !== 1'b0)  begin failures++; $display("FAIL rst_miso_oe got=%b exp=0", miso_oe); end
        checks++; if (miso !== 1'b0)     begin failures++; $display("FAIL rst_miso got=%b exp=0", miso); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        ssn = 1'b1;
        sck = cpol_m;
        clk_wait(2);
        rst = 1'b0;
        clk_wait(HP * 10);
        checks++; if (rv_count - rv0 !== 0) begin failures++; $display("FAIL rst_no_rv got=%0d exp=0", rv_count - rv0); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    endtask

    initial begin
        rst      = 1'b1;
        spcon_s  = 8'h00;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        sck      = 1'b0;
        mosi     = 1'b0;
        ssn      = 1'b1;
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_disable();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
